// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/1-write register file with a per-entry pending scoreboard and registered reads.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
`default_nettype none

module regfile_sb #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 5,
  parameter int          SP_IDX  = 29,
  parameter int unsigned SP_INIT = 252
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic              ReadEn,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] IssueRegister,
  input  logic              IssueValid,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              ReadPending1,
  output logic              ReadPending2,
  output logic              ReadValid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  sb;
  logic [DEPTH-1:0]  sb_next;
  logic              wr_hit;
  logic              iss_hit;
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];
  logic              rpend [2];

  assign wr_hit   = RegWrite && (WriteRegister != '0);
  assign iss_hit  = IssueValid && (IssueRegister != '0);
  assign raddr[0] = ReadRegister1;
  assign raddr[1] = ReadRegister2;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i == SP_IDX && SP_IDX != 0) ? DATA_W'(SP_INIT) : '0;
      end
    end else if (wr_hit) begin
      mem[WriteRegister] <= WriteData;
    end
  end

  // Issue is applied after the write clear so a same-cycle issue wins.
  always_comb begin
    sb_next = sb;
    if (wr_hit) begin
      sb_next[WriteRegister] = 1'b0;
    end
    if (iss_hit) begin
      sb_next[IssueRegister] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sb <= '0;
    end else begin
      sb <= sb_next;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = mem[raddr[p]];
      rpend[p] = sb[raddr[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (raddr[p] == WriteRegister)) begin
        rdata[p] = WriteData;
        rpend[p] = sb_next[raddr[p]];
      end
`endif
      if (raddr[p] == '0) begin
        rdata[p] = '0;
        rpend[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ReadData1    <= '0;
      ReadData2    <= '0;
      ReadPending1 <= 1'b0;
      ReadPending2 <= 1'b0;
      ReadValid    <= 1'b0;
    end else begin
      ReadValid <= ReadEn;
      if (ReadEn) begin
        ReadData1    <= rdata[0];
        ReadData2    <= rdata[1];
        ReadPending1 <= rpend[0];
        ReadPending2 <= rpend[1];
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth is 2^ADDR_W.
- SP_IDX, 29, index of the stack-pointer register.
- SP_INIT, 252, reset value of register SP_IDX.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- Clk, in, 1, single clock; all state updates on the rising edge.
- Rst_n, in, 1, asynchronous active-low reset.
- ReadRegister1, in, ADDR_W, read port 1 address.
- ReadRegister2, in, ADDR_W, read port 2 address.
- ReadEn, in, 1, read request for both ports.
- WriteRegister, in, ADDR_W, write address.
- WriteData, in, DATA_W, write data.
- RegWrite, in, 1, write strobe; also clears the scoreboard bit of WriteRegister.
- IssueRegister, in, ADDR_W, destination being claimed by an in-flight instruction.
- IssueValid, in, 1, sets the scoreboard bit of IssueRegister.
- ReadData1, out, DATA_W, registered read data, port 1.
- ReadData2, out, DATA_W, registered read data, port 2.
- ReadPending1, out, 1, registered scoreboard bit for the port 1 address.
- ReadPending2, out, 1, registered scoreboard bit for the port 2 address.
- ReadValid, out, 1, one-cycle pulse marking fresh read outputs.

Function
REQ-003 Storage SHALL be 2^ADDR_W entries of DATA_W bits, plus one scoreboard bit per entry.

REQ-004 On a rising Clk with RegWrite=1 and WriteRegister!=0, entry[WriteRegister] SHALL take WriteData.
- Writes to address 0 SHALL be discarded.

REQ-005 Reads SHALL proceed independently of RegWrite; a read is never suppressed by a concurrent write.

REQ-006 On a rising Clk with ReadEn=1, the block SHALL register the following, giving a latency of 1 cycle:
- ReadData1/2 from the addressed entries.
- ReadPending1/2 from the addressed scoreboard bits.
- ReadValid=1.

REQ-007 With ReadEn=0, ReadData1/2 and ReadPending1/2 SHALL hold their values, and ReadValid SHALL be 0 on the next cycle.

REQ-008 Address 0 SHALL always read data 0 and pending 0.

REQ-009 Both read ports MAY address the same entry, and each SHALL return identical results.

REQ-010 On a rising Clk with IssueValid=1 and IssueRegister!=0, sb[IssueRegister] SHALL be set to 1.

REQ-011 On a rising Clk with RegWrite=1 and WriteRegister!=0, sb[WriteRegister] SHALL be cleared to 0.

REQ-012 If the same nonzero address is both issued and written in one cycle, set SHALL win: the bit ends at 1 and the data is still written.

REQ-013 Re-issuing an address that is already pending SHALL leave its bit at 1; the scoreboard does not count issues.

Reset
REQ-014 While Rst_n=0, asynchronously and irrespective of Clk:
- All entries SHALL be 0, except entry[SP_IDX]=SP_INIT.
- All scoreboard bits SHALL be 0.
- ReadData1/2, ReadPending1/2 and ReadValid SHALL all be 0.

REQ-015 Reset asserted mid-operation SHALL discard any write, issue or read occurring in that cycle.
- The first rising Clk after Rst_n deasserts SHALL operate normally.

REQ-016 If SP_IDX=0, the SP_INIT value SHALL be ignored and address 0 SHALL remain 0.

Configuration
REQ-017 The macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding when a read address equals a nonzero WriteRegister with RegWrite=1 in the same cycle.
- Defined: ReadData returns WriteData (write-first), and ReadPending returns the post-update bit, i.e. 0 unless the same address is issued in that cycle.
- Undefined: ReadData returns the old entry value, and ReadPending returns the pre-update bit (read-first).
- All other behaviour SHALL be identical in both builds.

Verification
REQ-018 Reset: assert Rst_n=0 with Clk stopped, then read addresses 29 and 5 after release.
- Required: ReadData1=252, ReadData2=0, ReadPending=0, ReadValid=1 one cycle after ReadEn.

REQ-019 Zero register: write 0xDEADBEEF to address 0, issue address 0, then read address 0.
- Required: ReadData=0, ReadPending=0.

REQ-020 Scoreboard: issue address 8, read address 8, write 0x1234 to address 8, read address 8 again.
- Required: first read ReadPending1=1; second read ReadPending1=0 with ReadData1=0x1234.

REQ-021 Same-cycle issue and write: issue address 9 and write 0x55 to address 9 in one cycle, then read address 9.
- Required: ReadPending=1, ReadData=0x55.

REQ-022 Bypass: write 0xA5A5A5A5 to address 10 while reading address 10 on both ports, with the entry previously 0x1.
- With REGFILE_BYPASS_EN: both ports return 0xA5A5A5A5.
- Without it: both ports return 0x1; the next read returns 0xA5A5A5A5.

REQ-023 Hold and mid-read reset: read address 29, drop ReadEn for 3 cycles, then assert Rst_n=0.
- Required: ReadData holds 252 with ReadValid=0, then all outputs go to 0 immediately on reset.
